// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: state encoding and parameter derivations shared by the LUT config loader
package lut_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r < 1 ? 1 : r;
  endfunction
  function automatic int cfg_width(input int inputs);
    return 2 * (1 << inputs) + 1;
  endfunction
  function automatic int words_per_lut(input int cfg_w, input int word_w);
    return (cfg_w + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/lut_cfg_loader_assembler.sv
// cfg_word_assembler: packs WORD_W words into a CFG_W frame
// cclk/rst_n clock and async active-low reset; clr empties the frame and
// rewinds the word counter; we writes data as the next word; frame_nxt is
// the frame including the word being written this cycle; last flags the final word.
module cfg_word_assembler
  import lut_cfg_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CFG_W = 33,
  localparam int WORDS = words_per_lut(CFG_W, WORD_W),
  localparam int CNT_W = clog2(WORDS)
) (
  input  logic              cclk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [WORD_W-1:0] data,
  output logic [CFG_W-1:0]  frame_nxt,
  output logic              last
);
  logic [CFG_W-1:0] frame;
  logic [CNT_W-1:0] cnt;
  assign last = cnt == CNT_W'(WORDS - 1);
  // bits of the final word above CFG_W-1 have no destination and are dropped
  always_comb begin
    frame_nxt = frame;
    for (int b = 0; b < CFG_W; b++)
      if (we && b / WORD_W == int'(cnt)) frame_nxt[b] = data[b % WORD_W];
  end
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      frame <= '0;
      cnt <= '0;
    end else if (clr) begin
      frame <= '0;
      cnt <= '0;
    end else if (we) begin
      frame <= frame_nxt;
      cnt <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: streams config words into frames and commits one frame per LUT
// cclk/rst_n clock and async active-low reset; start begins a pass from IDLE;
// cfg_data/cfg_valid/cfg_ready word stream; config_out shared frame bus;
// cen_out one-hot enable pulsed in COMMIT; lut_idx LUT being loaded;
// busy high outside IDLE; done one-cycle end-of-pass pulse.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter int NUM_LUTS = 8,
  parameter int WORD_W = 8,
  localparam int CFG_W = cfg_width(INPUTS),
  localparam int IDX_W = clog2(NUM_LUTS)
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CFG_W-1:0]    config_out,
  output logic [NUM_LUTS-1:0] cen_out,
  output logic [IDX_W-1:0]    lut_idx,
  output logic                busy,
  output logic                done
);
  state_t state;
  logic we, clr, last;
  logic [CFG_W-1:0] frame_nxt;
  assign we = cfg_valid && cfg_ready;
  assign clr = (state == IDLE && start) || state == COMMIT;
  assign busy = state != IDLE;
  cfg_word_assembler #(.WORD_W(WORD_W), .CFG_W(CFG_W)) u_asm (
    .cclk(cclk),
    .rst_n(rst_n),
    .clr(clr),
    .we(we),
    .data(cfg_data),
    .frame_nxt(frame_nxt),
    .last(last)
  );
  // config_out is loaded on the edge entering COMMIT so it is already stable
  // while cen_out is high
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cfg_ready <= 1'b0;
      config_out <= '0;
      cen_out <= '0;
      lut_idx <= '0;
      done <= 1'b0;
    end else begin
      cen_out <= '0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          lut_idx <= '0;
          cfg_ready <= 1'b1;
        end
        LOAD: if (we && last) begin
          state <= COMMIT;
          cfg_ready <= 1'b0;
          config_out <= frame_nxt;
          cen_out <= NUM_LUTS'(1) << lut_idx;
        end
        COMMIT: if (lut_idx == IDX_W'(NUM_LUTS - 1)) begin
          state <= DONE;
          done <= 1'b1;
        end else begin
          state <= LOAD;
          lut_idx <= lut_idx + 1'b1;
          cfg_ready <= 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: randomized self-checking bench for lut_cfg_loader
module tb_lut_cfg_loader;
  localparam int N = 2, W = 8, CW = 33, WPL = 5;
  logic cclk = 0, rst_n = 0, start = 0, cfg_valid = 0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, busy, done;
  logic [CW-1:0] config_out;
  logic [N-1:0] cen_out;
  logic [0:0] lut_idx;
  int n_chk = 0, n_pass = 0;
  logic [W-1:0] stim [N*WPL];
  logic [CW-1:0] cap [N];
  int cen_cnt [N];
  int done_cnt;
  bit chk_on = 0;
  int m_ph, m_n, m_lut;
  logic [WPL*W-1:0] m_acc;
  logic e_rdy, e_done;
  logic [N-1:0] e_cen;
  logic [CW-1:0] e_cfg;

  always #5 cclk = ~cclk;

  lut_cfg_loader #(.INPUTS(4), .NUM_LUTS(N), .WORD_W(W)) dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .config_out(config_out),
    .cen_out(cen_out), .lut_idx(lut_idx), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [CW-1:0] put(input logic [WPL*W-1:0] acc, input int n, input logic [W-1:0] d);
    acc[n*W +: W] = d;
    return acc[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] exp_lut(input int i);
    logic [WPL*W-1:0] a;
    for (int k = 0; k < WPL; k++) a[k*W +: W] = stim[i*WPL+k];
    return a[CW-1:0];
  endfunction

  // phases: 0 idle, 1 collecting words, 2 commit cycle, 3 done cycle
  always @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      m_ph <= 0; m_n <= 0; m_lut <= 0;
      e_rdy <= 0; e_cen <= '0; e_cfg <= '0; e_done <= 0;
    end else begin
      e_cen <= '0;
      e_done <= 0;
      case (m_ph)
        0: if (start) begin m_ph <= 1; m_lut <= 0; m_n <= 0; e_rdy <= 1; end
        1: if (cfg_valid && e_rdy) begin
          m_acc[m_n*W +: W] <= cfg_data;
          if (m_n == WPL - 1) begin
            m_ph <= 2; m_n <= 0; e_rdy <= 0;
            e_cfg <= put(m_acc, m_n, cfg_data);
            e_cen <= N'(1) << m_lut;
          end else m_n <= m_n + 1;
        end
        2: if (m_lut == N - 1) begin m_ph <= 3; e_done <= 1; end
           else begin m_ph <= 1; m_lut <= m_lut + 1; e_rdy <= 1; end
        default: m_ph <= 0;
      endcase
    end

  always @(negedge cclk)
    if (chk_on && rst_n) begin
      chk("cfg_ready", cfg_ready, e_rdy);
      chk("cen_out", cen_out, e_cen);
      chk("config_out", config_out, e_cfg);
      chk("lut_idx", lut_idx, m_lut);
      chk("busy", busy, m_ph != 0);
      chk("done", done, e_done);
      chk("cen_onehot", $countones(cen_out) <= 1, 1);
      for (int i = 0; i < N; i++)
        if (cen_out[i]) begin cap[i] = config_out; cen_cnt[i]++; end
      if (done) done_cnt++;
    end

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin cap[i] = '0; cen_cnt[i] = 0; end
    done_cnt = 0;
  endtask

  task automatic rand_stim();
    for (int k = 0; k < N*WPL; k++) stim[k] = W'($urandom);
  endtask

  // gap: 0 back-to-back, 1 two idle cycles per word, 2 random 0..3 idle cycles
  task automatic run_pass(input int gap, input bit sl, input bit sd, input int abort_at);
    bit got, acc;
    int g;
    start = 1;
    @(posedge cclk); #1 start = 0;
    for (int k = 0; k < N*WPL; k++) begin
      if (k == abort_at) begin
        cfg_valid = 0;
        rst_n = 0;
        #1 rst_n = 1;
        return;
      end
      g = gap == 0 ? 0 : gap == 1 ? 2 : int'($urandom_range(0, 3));
      for (int c = 0; c < g; c++) begin
        cfg_valid = 0;
        cfg_data = W'($urandom);
        @(posedge cclk); #1;
      end
      cfg_valid = 1;
      cfg_data = stim[k];
      got = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge cclk);
        acc = cfg_ready;
        if (sl && k == 2) start = 1;
        @(posedge cclk); #1 start = 0;
        if (acc) begin got = 1; break; end
      end
      if (!got) chk("word_timeout", 0, 1);
      cfg_valid = 0;
    end
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge cclk);
      if (done) begin got = 1; if (sd) start = 1; break; end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge cclk); #1 start = 0;
  endtask

  initial begin
    repeat (2) @(posedge cclk);
    #1 rst_n = 1;
    chk_on = 1;
    start = 1;
    @(posedge cclk); #1 start = 0;
    @(posedge cclk); #1;
    rst_n = 0;
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cen_out", cen_out, 0);
    chk("rst_config_out", config_out, 0);
    chk("rst_lut_idx", lut_idx, 0);
    chk("rst_done", done, 0);
    #1 rst_n = 1;
    @(posedge cclk); #1;

    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFE};
    clear_stats();
    run_pass(0, 0, 0, -1);
    chk("lut0_frame", cap[0], 33'h1_0403_0201);
    chk("lut1_frame", cap[1], 33'h0_DDCC_BBAA);
    chk("lut0_cen_cnt", cen_cnt[0], 1);
    chk("lut1_cen_cnt", cen_cnt[1], 1);
    chk("done_cnt", done_cnt, 1);

    clear_stats();
    run_pass(1, 1, 1, -1);
    repeat (3) @(posedge cclk);
    #1;
    chk("stall_lut0_frame", cap[0], 33'h1_0403_0201);
    chk("stall_lut1_frame", cap[1], 33'h0_DDCC_BBAA);
    chk("stall_cen_cnt", cen_cnt[0] + cen_cnt[1], 2);
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_done_cnt", done_cnt, 1);

    rand_stim();
    clear_stats();
    run_pass(0, 0, 0, WPL + 3);
    @(posedge cclk); #1;
    chk("abort_lut0_cen", cen_cnt[0], 1);
    chk("abort_lut1_cen", cen_cnt[1], 0);
    chk("abort_busy", busy, 0);
    chk("abort_lut0_frame", cap[0], exp_lut(0));

    for (int p = 0; p < 6; p++) begin
      rand_stim();
      clear_stats();
      run_pass(p == 0 ? 0 : 2, 0, 0, -1);
      for (int i = 0; i < N; i++) begin
        chk("rand_frame", cap[i], exp_lut(i));
        chk("rand_cen_cnt", cen_cnt[i], 1);
      end
      chk("rand_done_cnt", done_cnt, 1);
      @(posedge cclk); #1;
    end
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
